// File: rtl/burst_coalescer_if.sv
// Bus bundle between the banks arbiter, the timing controller, the memory-side
// data path and the returner on one side and the burst coalescer on the other.
//
// Signal groups:
//   in_*    : single-beat request from the arbiter (valid/ready), flush
//   iss_*   : closed burst offered to the timing controller (valid/ready)
//   wr_*    : combinational write-data lookup by slot and beat
//   rd_*    : read data beats written back by the memory side
//   cmpl_*  : burst finished on the memory side
//   ret_*   : per-beat return to the returner (valid/ready)
//   empty_count : number of EMPTY slots
//
// Modports: master = the surrounding system, slave = the coalescer.
interface burst_coalescer_if #(
  parameter int NUM_BURSTS = 4,
  parameter int BURST_LEN  = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int IDX_W      = 5
);
  localparam int NB_W = $clog2(NUM_BURSTS);
  localparam int BL_W = $clog2(BURST_LEN);

  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_W-1:0]    in_addr;
  logic                 in_type;
  logic [DATA_W-1:0]    in_data;
  logic [IDX_W-1:0]     in_index;
  logic                 flush;
  logic [NB_W:0]        empty_count;

  logic                 iss_valid;
  logic                 iss_ready;
  logic [NB_W-1:0]      iss_id;
  logic [ADDR_W-BL_W-1:0] iss_key;
  logic                 iss_type;
  logic [BURST_LEN-1:0] iss_mask;

  logic [NB_W-1:0]      wr_id;
  logic [BL_W-1:0]      wr_beat;
  logic [DATA_W-1:0]    wr_data;

  logic                 rd_valid;
  logic [NB_W-1:0]      rd_id;
  logic [BL_W-1:0]      rd_beat;
  logic [DATA_W-1:0]    rd_data;

  logic                 cmpl_valid;
  logic [NB_W-1:0]      cmpl_id;

  logic                 ret_valid;
  logic                 ret_ready;
  logic                 ret_type;
  logic [IDX_W-1:0]     ret_index;
  logic [DATA_W-1:0]    ret_data;

  modport master (
    output in_valid, in_addr, in_type, in_data, in_index, flush,
           iss_ready, wr_id, wr_beat, rd_valid, rd_id, rd_beat, rd_data,
           cmpl_valid, cmpl_id, ret_ready,
    input  in_ready, empty_count, iss_valid, iss_id, iss_key, iss_type,
           iss_mask, wr_data, ret_valid, ret_type, ret_index, ret_data
  );

  modport slave (
    input  in_valid, in_addr, in_type, in_data, in_index, flush,
           iss_ready, wr_id, wr_beat, rd_valid, rd_id, rd_beat, rd_data,
           cmpl_valid, cmpl_id, ret_ready,
    output in_ready, empty_count, iss_valid, iss_id, iss_key, iss_type,
           iss_mask, wr_data, ret_valid, ret_type, ret_index, ret_data
  );
endinterface

// File: rtl/burst_coalescer.sv
// Burst coalescer: gathers single-beat requests into NUM_BURSTS burst slots
// keyed by (address key, type), closes slots on full / idle timeout / flush,
// offers closed bursts to the timing controller, captures read data and finally
// returns every request beat-by-beat to the returner.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : burst_coalescer_if.slave (request, issue, write lookup, read data,
//          completion and return channels)
//
// Slot lifecycle: EMPTY -> FILLING -> CLOSED -> ISSUED -> RETURNING -> EMPTY.
module burst_coalescer #(
  parameter int NUM_BURSTS = 4,
  parameter int BURST_LEN  = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int IDX_W      = 5,
  parameter int TIMEOUT    = 8
) (
  input logic              clk,
  input logic              rst,
  burst_coalescer_if.slave bus
);

  localparam int NB_W  = $clog2(NUM_BURSTS);
  localparam int BL_W  = $clog2(BURST_LEN);
  localparam int KEY_W = ADDR_W - BL_W;
  localparam int CNT_W = NB_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_EMPTY, S_FILLING, S_CLOSED, S_ISSUED, S_RETURNING
  } slot_state_e;

  // Per-slot control state
  slot_state_e          state_q [NUM_BURSTS];
  logic [KEY_W-1:0]     key_q   [NUM_BURSTS];
  logic                 type_q  [NUM_BURSTS];
  logic [BURST_LEN-1:0] mask_q  [NUM_BURSTS];
  logic [TO_W-1:0]      idle_q  [NUM_BURSTS];

  // Per-beat storage
  logic [IDX_W-1:0]     index_q [NUM_BURSTS][BURST_LEN];
  logic [DATA_W-1:0]    data_q  [NUM_BURSTS][BURST_LEN];

  logic [CNT_W-1:0]     empty_count_q, empty_count_d;
  logic                 iss_hold_q;
  logic [NB_W-1:0]      iss_hold_id_q;

  logic                 ret_valid_q, ret_type_q;
  logic [IDX_W-1:0]     ret_index_q;
  logic [DATA_W-1:0]    ret_data_q;
  logic [NB_W-1:0]      ret_slot_q;
  logic [BL_W-1:0]      ret_beat_q;

  // Request decode
  logic [KEY_W-1:0] in_key;
  logic [BL_W-1:0]  in_beat;
  logic             match_any, match_dup, any_empty;
  logic [NB_W-1:0]  match_id, alloc_id, store_id;
  logic             accept, do_merge, do_alloc, dup_close;

  assign in_key  = bus.in_addr[ADDR_W-1:BL_W];
  assign in_beat = bus.in_addr[BL_W-1:0];

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    match_any = 1'b0;
    match_id  = '0;
    any_empty = 1'b0;
    alloc_id  = '0;
    // Descending scan so the lowest index wins.
    for (int s = NUM_BURSTS - 1; s >= 0; s--) begin
      if (state_q[s] == S_FILLING && key_q[s] == in_key && type_q[s] == bus.in_type) begin
        match_any = 1'b1;
        match_id  = NB_W'(s);
      end
      if (state_q[s] == S_EMPTY) begin
        any_empty = 1'b1;
        alloc_id  = NB_W'(s);
      end
    end
  end

  assign match_dup    = match_any & mask_q[match_id][in_beat];
  assign bus.in_ready = (match_any & ~match_dup) | any_empty;
  assign accept       = bus.in_valid & bus.in_ready;
  assign do_merge     = accept & match_any & ~match_dup;
  // A duplicate beat opens a fresh slot just like a miss does.
  assign do_alloc     = accept & ~(match_any & ~match_dup);
  assign dup_close    = accept & match_dup;
  assign store_id     = do_merge ? match_id : alloc_id;

  // Issue selection: once offered and stalled, the same slot stays presented
  // even if a lower-index slot closes meanwhile.
  logic            iss_any, iss_fire;
  logic [NB_W-1:0] iss_low, iss_sel;

  always_comb begin
    iss_any = 1'b0;
    iss_low = '0;
    for (int s = NUM_BURSTS - 1; s >= 0; s--) begin
      if (state_q[s] == S_CLOSED) begin
        iss_any = 1'b1;
        iss_low = NB_W'(s);
      end
    end
  end

  assign iss_sel       = iss_hold_q ? iss_hold_id_q : iss_low;
  assign iss_fire      = iss_any & bus.iss_ready;
  assign bus.iss_valid = iss_any;
  assign bus.iss_id    = iss_sel;
  assign bus.iss_key   = key_q[iss_sel];
  assign bus.iss_type  = type_q[iss_sel];
  assign bus.iss_mask  = mask_q[iss_sel];

  assign bus.wr_data   = data_q[bus.wr_id][bus.wr_beat];

  // Return selection. The beat sitting in the output register is still set in
  // its mask until accepted, so it is masked out here to allow back-to-back
  // beats without sending it twice.
  logic                 ret_cand_any, ret_load, ret_pop;
  logic [NB_W-1:0]      ret_cand_slot;
  logic [BL_W-1:0]      ret_cand_beat, low_b;
  logic [BURST_LEN-1:0] pend;

  always_comb begin
    ret_cand_any  = 1'b0;
    ret_cand_slot = '0;
    ret_cand_beat = '0;
    pend          = '0;
    low_b         = '0;
    for (int s = NUM_BURSTS - 1; s >= 0; s--) begin
      pend = mask_q[s];
      if (ret_valid_q && ret_slot_q == NB_W'(s)) pend[ret_beat_q] = 1'b0;
      low_b = '0;
      for (int b = BURST_LEN - 1; b >= 0; b--) begin
        if (pend[b]) low_b = BL_W'(b);
      end
      if (state_q[s] == S_RETURNING && pend != '0) begin
        ret_cand_any  = 1'b1;
        ret_cand_slot = NB_W'(s);
        ret_cand_beat = low_b;
      end
    end
  end

  assign ret_pop  = ret_valid_q & bus.ret_ready;
  assign ret_load = ret_cand_any & (~ret_valid_q | bus.ret_ready);

  // Slots leaving RETURNING this cycle versus the one allocated this cycle.
  logic [CNT_W-1:0] free_cnt;

  always_comb begin
    free_cnt = '0;
    for (int s = 0; s < NUM_BURSTS; s++) begin
      if (state_q[s] == S_RETURNING && mask_q[s] == '0) free_cnt = free_cnt + CNT_W'(1);
    end
    empty_count_d = empty_count_q + free_cnt - CNT_W'(do_alloc);
  end

  assign bus.empty_count = empty_count_q;
  assign bus.ret_valid   = ret_valid_q;
  assign bus.ret_type    = ret_type_q;
  assign bus.ret_index   = ret_index_q;
  assign bus.ret_data    = ret_data_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_BURSTS; s++) begin
        state_q[s] <= S_EMPTY;
        key_q[s]   <= '0;
        type_q[s]  <= 1'b0;
        mask_q[s]  <= '0;
        idle_q[s]  <= '0;
      end
      empty_count_q <= CNT_W'(NUM_BURSTS);
      iss_hold_q    <= 1'b0;
      iss_hold_id_q <= '0;
      ret_valid_q   <= 1'b0;
      ret_type_q    <= 1'b0;
      ret_index_q   <= '0;
      ret_data_q    <= '0;
      ret_slot_q    <= '0;
      ret_beat_q    <= '0;
    end else begin
      for (int s = 0; s < NUM_BURSTS; s++) begin
        case (state_q[s])
          S_EMPTY: begin
            if (do_alloc && alloc_id == NB_W'(s)) begin
              state_q[s] <= S_FILLING;
              key_q[s]   <= in_key;
              type_q[s]  <= bus.in_type;
              mask_q[s]  <= BURST_LEN'(1) << in_beat;
              idle_q[s]  <= '0;
            end
          end
          S_FILLING: begin
            if (do_merge && match_id == NB_W'(s)) begin
              // An accept beats a same-cycle timeout; flush still closes.
              mask_q[s][in_beat] <= 1'b1;
              idle_q[s]          <= '0;
              if (bus.flush) state_q[s] <= S_CLOSED;
            end else if (dup_close && match_id == NB_W'(s)) begin
              state_q[s] <= S_CLOSED;
            end else if (bus.flush || mask_q[s] == '1 ||
                         idle_q[s] == TO_W'(TIMEOUT - 1)) begin
              // idle_q counts completed idle cycles; this one is the TIMEOUT-th.
              state_q[s] <= S_CLOSED;
            end else begin
              idle_q[s] <= idle_q[s] + TO_W'(1);
            end
          end
          S_CLOSED: begin
            if (iss_fire && iss_sel == NB_W'(s)) state_q[s] <= S_ISSUED;
          end
          S_ISSUED: begin
            if (bus.cmpl_valid && bus.cmpl_id == NB_W'(s)) state_q[s] <= S_RETURNING;
          end
          S_RETURNING: begin
            if (mask_q[s] == '0) begin
              state_q[s] <= S_EMPTY;
            end else if (ret_pop && ret_slot_q == NB_W'(s)) begin
              mask_q[s][ret_beat_q] <= 1'b0;
            end
          end
          default: state_q[s] <= S_EMPTY;
        endcase
      end

      empty_count_q <= empty_count_d;
      iss_hold_q    <= iss_any & ~bus.iss_ready;
      iss_hold_id_q <= iss_sel;

      if (ret_load) begin
        ret_valid_q <= 1'b1;
        ret_slot_q  <= ret_cand_slot;
        ret_beat_q  <= ret_cand_beat;
        ret_type_q  <= type_q[ret_cand_slot];
        ret_index_q <= index_q[ret_cand_slot][ret_cand_beat];
        ret_data_q  <= data_q[ret_cand_slot][ret_cand_beat];
      end else if (ret_pop) begin
        ret_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the beat storage is deliberately not reset; a beat is only ever read
  // after its mask bit was set, which always writes the index first.
  always_ff @(posedge clk) begin
    if (accept) begin
      index_q[store_id][in_beat] <= bus.in_index;
      if (bus.in_type) data_q[store_id][in_beat] <= bus.in_data;
    end
    if (bus.rd_valid && state_q[bus.rd_id] == S_ISSUED) begin
      data_q[bus.rd_id][bus.rd_beat] <= bus.rd_data;
    end
  end

endmodule
